// File: rtl/mem_responder_pkg.sv
// Shared definitions for the CPU memory-protocol responder: FSM encoding,
// beat selection and wait-state limits.
package mem_responder_pkg;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 15;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ACC_HI  = 4'd1,
    ST_WAIT_HI = 4'd2,
    ST_CAP_HI  = 4'd3,
    ST_ACC_LO  = 4'd4,
    ST_WAIT_LO = 4'd5,
    ST_CAP_LO  = 4'd6,
    ST_DONE    = 4'd7,
    ST_TURN    = 4'd8
  } state_t;

  localparam logic BEAT_HI = 1'b1;
  localparam logic BEAT_LO = 1'b0;

  // Low-beat states drive the second halfword; everything else presents the base address.
  function automatic logic beat_of(input state_t s);
    return (s == ST_ACC_LO || s == ST_WAIT_LO || s == ST_CAP_LO) ? BEAT_LO : BEAT_HI;
  endfunction

endpackage

// File: rtl/mem_responder_wait_counter.sv
// Loadable 4-bit down-counter with a zero flag, used to pace SRAM wait states.
module wait_counter
  import mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // NOTE: state registers use non-blocking assignments and reset asynchronously,
  // so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_responder.sv
// Target-side responder for the CPU memory request protocol; splits word
// accesses into two big-endian halfword beats on a synchronous 16-bit SRAM.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] MemAddr,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              SaveHalf,
  input  logic              LoadHalf,
  input  logic [31:0]       MemWriteData,
  output logic [31:0]       readData,
  output logic              MemOK,
  output logic              prot_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata,
  output logic              sram_ce,
  output logic              sram_we
);

  localparam int               LP_WAIT     = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;
  localparam bit               LP_HAS_WAIT = (LP_WAIT != 0);
  // The counter is loaded in the access cycle, so it holds one less than the wait length.
  localparam logic [CNT_W-1:0] LP_LOAD     = LP_HAS_WAIT ? CNT_W'(LP_WAIT - 1) : '0;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_write;
  logic              r_half;
  logic [31:0]       r_read_data;
  logic              r_prot_err;

  logic              w_accept;
  logic              w_req_half;
  logic              w_beat;
  logic [ADDR_W-1:0] w_lo_addr;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_zero;

  assign w_accept   = (r_state == ST_IDLE) && (MemRead || MemWrite);
  assign w_req_half = MemWrite ? SaveHalf : LoadHalf;
  assign w_beat     = beat_of(r_state);
  assign w_cnt_load = (r_state == ST_ACC_HI) || (r_state == ST_ACC_LO);
  assign w_cnt_dec  = (r_state == ST_WAIT_HI) || (r_state == ST_WAIT_LO);

  wait_counter u_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (LP_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the next-state value is defaulted first so no path through the case
  // leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_req_half ? ST_ACC_LO : ST_ACC_HI;
        end
      end
      ST_ACC_HI: begin
        if (LP_HAS_WAIT)  w_state_nxt = ST_WAIT_HI;
        else if (r_write) w_state_nxt = ST_ACC_LO;
        else              w_state_nxt = ST_CAP_HI;
      end
      ST_WAIT_HI: begin
        if (w_cnt_zero) w_state_nxt = r_write ? ST_ACC_LO : ST_CAP_HI;
      end
      ST_CAP_HI: w_state_nxt = ST_ACC_LO;
      ST_ACC_LO: begin
        if (LP_HAS_WAIT)  w_state_nxt = ST_WAIT_LO;
        else if (r_write) w_state_nxt = ST_DONE;
        else              w_state_nxt = ST_CAP_LO;
      end
      ST_WAIT_LO: begin
        if (w_cnt_zero) w_state_nxt = r_write ? ST_DONE : ST_CAP_LO;
      end
      ST_CAP_LO: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_TURN;
      ST_TURN:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // A simultaneous read+write request is serviced as the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_half      <= 1'b0;
      r_read_data <= '0;
      r_prot_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= MemAddr;
        r_wdata <= MemWriteData;
        r_write <= MemWrite;
        r_half  <= w_req_half;
        if (MemRead && MemWrite) r_prot_err <= 1'b1;
      end
      if (r_state == ST_CAP_HI) begin
        r_read_data[31:16] <= sram_rdata;
      end else if (r_state == ST_CAP_LO) begin
        if (r_half) r_read_data <= {16'h0000, sram_rdata};
        else        r_read_data[15:0] <= sram_rdata;
      end
    end
  end

  // Second beat wraps at the top of the address space.
  assign w_lo_addr  = r_half ? r_addr : (r_addr + ADDR_W'(1));
  assign sram_addr  = (w_beat == BEAT_HI) ? r_addr : w_lo_addr;
  assign sram_wdata = (w_beat == BEAT_HI) ? r_wdata[31:16] : r_wdata[15:0];
  assign sram_ce    = w_cnt_load;
  assign sram_we    = w_cnt_load && r_write;
  assign MemOK      = (r_state == ST_DONE);
  assign readData   = r_read_data;
  assign prot_err   = r_prot_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with no wait states (A) and
// one with two wait states (B), each backed by its own behavioural SRAM.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [14:0] a_addr, b_addr;
  logic        a_rd, a_wr, a_sh, a_lh, b_rd, b_wr, b_sh, b_lh;
  logic [31:0] a_wd, b_wd, a_rdata, b_rdata;
  logic        a_ok, a_perr, a_ce, a_we, b_ok, b_perr, b_ce, b_we;
  logic [14:0] a_saddr, b_saddr;
  logic [15:0] a_swd, b_swd;
  logic [15:0] a_srd = 16'h0000;
  logic [15:0] b_srd = 16'h0000;

  logic [15:0] mem_a [0:32767];
  logic [15:0] mem_b [0:32767];

  logic [63:0] ce_mask;
  logic [14:0] ce_addr [2];
  int          n_ce;

  mem_responder #(.WAIT_CYCLES(0), .ADDR_W(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .MemAddr(a_addr), .MemRead(a_rd), .MemWrite(a_wr),
    .SaveHalf(a_sh), .LoadHalf(a_lh), .MemWriteData(a_wd), .readData(a_rdata),
    .MemOK(a_ok), .prot_err(a_perr), .sram_addr(a_saddr), .sram_wdata(a_swd),
    .sram_rdata(a_srd), .sram_ce(a_ce), .sram_we(a_we)
  );

  mem_responder #(.WAIT_CYCLES(2), .ADDR_W(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .MemAddr(b_addr), .MemRead(b_rd), .MemWrite(b_wr),
    .SaveHalf(b_sh), .LoadHalf(b_lh), .MemWriteData(b_wd), .readData(b_rdata),
    .MemOK(b_ok), .prot_err(b_perr), .sram_addr(b_saddr), .sram_wdata(b_swd),
    .sram_rdata(b_srd), .sram_ce(b_ce), .sram_we(b_we)
  );

  // Synchronous SRAMs: read data appears the cycle after the strobe and holds.
  always @(posedge clk) begin
    if (a_ce) begin
      if (a_we) mem_a[a_saddr] = a_swd;
      else      a_srd <= mem_a[a_saddr];
    end
    if (b_ce) begin
      if (b_we) mem_b[b_saddr] = b_swd;
      else      b_srd <= mem_b[b_saddr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ok(input int sel);
    return (sel == 0) ? a_ok : b_ok;
  endfunction

  function automatic logic get_ce(input int sel);
    return (sel == 0) ? a_ce : b_ce;
  endfunction

  function automatic logic [14:0] get_saddr(input int sel);
    return (sel == 0) ? a_saddr : b_saddr;
  endfunction

  task automatic drive(input int sel, input logic rd, input logic wr, input logic half,
                       input logic [14:0] addr, input logic [31:0] wd);
    if (sel == 0) begin
      a_rd = rd; a_wr = wr; a_sh = half; a_lh = half; a_addr = addr; a_wd = wd;
    end else begin
      b_rd = rd; b_wr = wr; b_sh = half; b_lh = half; b_addr = addr; b_wd = wd;
    end
  endtask

  // Presents a request from IDLE, drops it after the sampling edge, then
  // measures the MemOK latency and records the SRAM strobes on the way.
  task automatic do_req(input int sel, input logic rd, input logic wr, input logic half,
                        input logic [14:0] addr, input logic [31:0] wd,
                        input int exp_lat, input string tag);
    int   k;
    logic done;
    drive(sel, rd, wr, half, addr, wd);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 15'h0000, 32'h0);
    ce_mask = '0;
    n_ce    = 0;
    k       = 0;
    done    = 1'b0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      if (get_ce(sel)) begin
        ce_mask[k] = 1'b1;
        if (n_ce < 2) ce_addr[n_ce] = get_saddr(sel);
        n_ce++;
      end
      if (get_ok(sel)) done = 1'b1;
    end
    check({tag, "_lat"}, 64'(k), 64'(exp_lat));
    @(negedge clk);
    check({tag, "_okpulse"}, 64'(get_ok(sel)), 64'h0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 15'h0000, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 15'h0000, 32'h0);
    for (int i = 0; i < 32768; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    mem_a[15'h0010] = 16'h1234;
    mem_a[15'h0011] = 16'hABCD;
    mem_a[15'h0021] = 16'h7777;
    mem_a[15'h7FFF] = 16'hCAFE;
    mem_a[15'h0000] = 16'hF00D;

    #12;
    check("rst_readData", 64'(a_rdata), 64'h0);
    check("rst_MemOK",    64'(a_ok),    64'h0);
    check("rst_prot_err", 64'(a_perr),  64'h0);
    check("rst_sram_ce",  64'(a_ce),    64'h0);
    check("rst_sram_we",  64'(a_we),    64'h0);
    check("rst_sram_addr",  64'(a_saddr), 64'h0);
    check("rst_sram_wdata", 64'(a_swd),   64'h0);
    check("rst_b_readData", 64'(b_rdata), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word read, no wait states: strobes at N+1 and N+3, MemOK at N+5.
    do_req(0, 1'b1, 1'b0, 1'b0, 15'h0010, 32'h0, 5, "t1_rd");
    check("t1_data",    64'(a_rdata), 64'h1234ABCD);
    check("t1_ce_mask", ce_mask,      64'h000000000000000A);

    // Word write then read with two wait states per beat.
    do_req(1, 1'b0, 1'b1, 1'b0, 15'h0100, 32'hDEADBEEF, 7, "t2_wr");
    check("t2_mem_hi",      64'(mem_b[15'h0100]), 64'hDEAD);
    check("t2_mem_lo",      64'(mem_b[15'h0101]), 64'hBEEF);
    check("t2_wr_readData", 64'(b_rdata),         64'h0);
    do_req(1, 1'b1, 1'b0, 1'b0, 15'h0100, 32'h0, 9, "t2_rd");
    check("t2_data", 64'(b_rdata), 64'hDEADBEEF);

    // Halfword write touches only mem[a]; halfword read zero-extends.
    do_req(0, 1'b0, 1'b1, 1'b1, 15'h0020, 32'hFFFF5A5A, 2, "t3_wr");
    check("t3_mem_a",  64'(mem_a[15'h0020]), 64'h5A5A);
    check("t3_mem_a1", 64'(mem_a[15'h0021]), 64'h7777);
    do_req(0, 1'b1, 1'b0, 1'b1, 15'h0020, 32'h0, 3, "t3_rd");
    check("t3_data", 64'(a_rdata), 64'h00005A5A);
    repeat (3) @(negedge clk);
    check("t3_hold", 64'(a_rdata), 64'h00005A5A);

    // Word read at the top of the address space wraps the second beat.
    do_req(0, 1'b1, 1'b0, 1'b0, 15'h7FFF, 32'h0, 5, "t4_rd");
    check("t4_addr_hi", 64'(ce_addr[0]), 64'h7FFF);
    check("t4_addr_lo", 64'(ce_addr[1]), 64'h0000);
    check("t4_data",    64'(a_rdata),    64'hCAFEF00D);

    // Read and write together: serviced as a write, sticky protocol error.
    check("t5_perr_before", 64'(a_perr), 64'h0);
    do_req(0, 1'b1, 1'b1, 1'b0, 15'h0040, 32'h11112222, 3, "t5_wr");
    check("t5_perr",   64'(a_perr),           64'h1);
    check("t5_mem_hi", 64'(mem_a[15'h0040]),  64'h1111);
    check("t5_mem_lo", 64'(mem_a[15'h0041]),  64'h2222);
    do_req(0, 1'b1, 1'b0, 1'b0, 15'h0040, 32'h0, 5, "t5_rd");
    check("t5_data",       64'(a_rdata), 64'h11112222);
    check("t5_perr_stays", 64'(a_perr),  64'h1);
    check("t5_b_perr",     64'(b_perr),  64'h0);

    // Reset asserted while instance B sits in WAIT_HI of a word read.
    drive(1, 1'b1, 1'b0, 1'b0, 15'h0100, 32'h0);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 1'b0, 15'h0000, 32'h0);
    @(negedge clk);
    check("t6_acc_ce", 64'(b_ce), 64'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_MemOK",    64'(b_ok),    64'h0);
    check("t6_rst_ce",       64'(b_ce),    64'h0);
    check("t6_rst_readData", 64'(b_rdata), 64'h0);
    check("t6_rst_perr_a",   64'(a_perr),  64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1, 1'b1, 1'b0, 1'b0, 15'h0100, 32'h0, 9, "t6_rd");
    check("t6_data", 64'(b_rdata), 64'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Target-side controller for the CPU memory request protocol: MemRead/MemWrite level requests, a 15-bit address, SaveHalf/LoadHalf size flags, and a one-cycle MemOK completion pulse.
- Services each request against an external synchronous 16-bit SRAM. A word access is split into two halfword beats, with a programmable number of wait states per beat.
- Sits between the CPU datapath and the physical SRAM, inside the memory manager, replacing direct RAM wiring.

Parameters:
- WAIT_CYCLES, 0, extra SRAM wait cycles per beat (0..15).
- ADDR_W, 15, halfword address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- MemAddr  in  ADDR_W  halfword address of the access
- MemRead  in  1  read request (level)
- MemWrite  in  1  write request (level)
- SaveHalf  in  1  write is a halfword (MemWriteData[15:0] only)
- LoadHalf  in  1  read is a halfword
- MemWriteData  in  32  store data
- readData  out  32  load result
- MemOK  out  1  completion pulse, exactly 1 cycle
- prot_err  out  1  sticky: MemRead and MemWrite were seen together
- sram_addr  out  ADDR_W  SRAM halfword address
- sram_wdata  out  16  SRAM write data
- sram_rdata  in  16  SRAM read data, valid the cycle after sram_ce
- sram_ce  out  1  SRAM access strobe
- sram_we  out  1  SRAM write enable (qualified by sram_ce)

Behaviour:
- Reset (asynchronous, active-low): FSM goes to IDLE. readData, MemOK, prot_err, sram_ce, sram_we, sram_addr and sram_wdata all go to 0. An in-flight write may be left partial; no recovery is attempted.
- Request sampling:
  - Requests are sampled only in IDLE. On acceptance, address, size, direction and write data are latched; later changes to the inputs are ignored until MemOK.
  - If MemRead and MemWrite are both high, the access is a write and prot_err is set. prot_err clears only on reset.
- Byte order: big-endian halfword order. The word at address a is {mem[a], mem[a+1]}.
  - The second beat address is (a+1) mod 2^ADDR_W; 0x7FFF wraps to 0x0000.
  - A halfword access touches only mem[a].
- FSM states: IDLE, ACC_HI, WAIT_HI, CAP_HI, ACC_LO, WAIT_LO, CAP_LO, DONE, TURN.
  - ACC_x: sram_ce=1 for 1 cycle, sram_addr = beat address. For writes, sram_we=1 and sram_wdata = beat data (hi beat: data[31:16], lo beat: data[15:0]; a halfword write uses data[15:0] in its single beat).
  - WAIT_x: sram_ce=0, address held, lasts WAIT_CYCLES cycles; skipped when WAIT_CYCLES=0. A 4-bit down-counter is loaded on entry.
  - CAP_x: reads only. Captures sram_rdata; the hi beat goes to readData[31:16].
- Beat sequence per access type:
  - Word read: ACC_HI, WAIT_HI, CAP_HI, ACC_LO, WAIT_LO, CAP_LO, DONE.
  - Halfword read: single beat at a, captured into readData[15:0] with readData[31:16]=0 (zero-extend), then DONE.
  - Word write: ACC_HI, WAIT_HI, ACC_LO, WAIT_LO, DONE.
  - Halfword write: ACC_LO (data[15:0] at address a), WAIT_LO, DONE.
- DONE: MemOK=1 for one cycle, then TURN. TURN is one cycle with requests ignored, so the CPU has time to drop or change its request; then IDLE.
- Latency from the request being sampled at the edge ending cycle N, with w = WAIT_CYCLES, MemOK is high in:
  - word read: N+5+2w
  - half read: N+3+w
  - word write: N+3+2w
  - half write: N+2+w
- readData is updated only in CAP states. It holds its value from MemOK until the next accepted read.
- Writes never alter readData.
- Back-to-back accepted requests are separated by at least 2 cycles (DONE, TURN).

Decomposition:
- Shared package holds:
  - state encoding (4-bit localparams ST_IDLE..ST_TURN);
  - beat select constants BEAT_HI/BEAT_LO;
  - MAX_WAIT=15.
- Sub-module wait_counter: loadable 4-bit down-counter with a zero flag, reusable by the VGA/IO responders.

Test Plan:
1. WAIT_CYCLES=0. Preload mem[0x0010]=0x1234, mem[0x0011]=0xABCD. MemRead word @0x0010 sampled cycle N -> MemOK only in N+5, readData=0x1234ABCD, sram_ce pulses at N+1 and N+3.
2. WAIT_CYCLES=2. MemWrite word 0xDEADBEEF @0x0100, then word read @0x0100 -> write MemOK at N+7; read returns 0xDEADBEEF with MemOK at read-sample+9; mem[0x0100]=0xDEAD, mem[0x0101]=0xBEEF.
3. Halfword write 0xFFFF5A5A @0x0020 (SaveHalf=1), then halfword read (LoadHalf=1) -> mem[0x0020]=0x5A5A, mem[0x0021] unchanged, readData=0x00005A5A.
4. Word read @0x7FFF -> beats at sram_addr 0x7FFF then 0x0000; readData = {mem[0x7FFF], mem[0x0000]}.
5. MemRead and MemWrite both high @0x0040 with data 0x11112222 -> write performed, prot_err=1 and stays set through later accesses; a read of 0x0040 returns 0x11112222.
6. rst_n low mid word read (in WAIT_HI) -> immediately MemOK=0, sram_ce=0, readData=0. After release, IDLE, and a fresh request completes with nominal latency.
